// File: rtl/shared_mem_arbiter_if.sv
// Per-core memory and lock handshakes plus the shared synchronous memory port.
// The arbiter takes the slave side; cores and the memory take the master side.
interface shared_mem_arbiter_if #(
    parameter int NCORE = 4
);
    logic [NCORE*16-1:0] core_read_adr;
    logic [NCORE*16-1:0] core_write_adr;
    logic [NCORE*16-1:0] core_write_dat;
    logic [NCORE-1:0]    core_read;
    logic [NCORE-1:0]    core_write;
    logic [NCORE*16-1:0] core_dat;
    logic [NCORE-1:0]    core_ac;
    logic [NCORE*10-1:0] core_lock_adr;
    logic [NCORE-1:0]    core_lock_en;
    logic [NCORE-1:0]    core_unlock_en;
    logic [NCORE-1:0]    core_lock_ac;
    logic [15:0]         mem_adr;
    logic [15:0]         mem_wdat;
    logic                mem_we;
    logic                mem_re;
    logic [15:0]         mem_rdat;

    modport slave (
        input  core_read_adr, core_write_adr, core_write_dat, core_read, core_write,
               core_lock_adr, core_lock_en, core_unlock_en, mem_rdat,
        output core_dat, core_ac, core_lock_ac, mem_adr, mem_wdat, mem_we, mem_re
    );

    modport master (
        output core_read_adr, core_write_adr, core_write_dat, core_read, core_write,
               core_lock_adr, core_lock_en, core_unlock_en, mem_rdat,
        input  core_dat, core_ac, core_lock_ac, mem_adr, mem_wdat, mem_we, mem_re
    );
endinterface

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter serializing NCORE cores onto one synchronous memory port,
// plus an independent spin-lock manager holding one 10-bit lock address per core.
module shared_mem_arbiter #(
    parameter int NCORE = 4,
    parameter int LAT   = 1
) (
    input  logic                clk,
    input  logic                reset,
    shared_mem_arbiter_if.slave bus
);

    localparam int IW = $clog2(NCORE);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    // Returns {found, index} of the first set request at or above ptr, wrapping mod NCORE.
    function automatic logic [IW:0] rr_pick(input logic [NCORE-1:0] req, input logic [IW-1:0] ptr);
        logic [IW:0]   idx;
        logic          found;
        logic [IW-1:0] win;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NCORE; k++) begin
            idx = {1'b0, ptr} + (IW+1)'(k);
            if (idx >= (IW+1)'(NCORE)) idx = idx - (IW+1)'(NCORE);
            if (!found && req[idx[IW-1:0]]) begin
                found = 1'b1;
                win   = idx[IW-1:0];
            end
        end
        return {found, win};
    endfunction

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] win);
        return (win == IW'(NCORE - 1)) ? '0 : win + 1'b1;
    endfunction

    // Memory FSM state and registered outputs
    state_e              state_q;
    logic [IW-1:0]       rr_ptr_q;
    logic [IW-1:0]       win_q;
    logic                op_we_q;
    logic [CW-1:0]       cnt_q;
    logic [15:0]         mem_adr_q;
    logic [15:0]         mem_wdat_q;
    logic                mem_we_q;
    logic                mem_re_q;
    logic [NCORE-1:0]    core_ac_q;
    logic [NCORE*16-1:0] core_dat_q;

    logic [NCORE-1:0] mem_req;
    logic [IW:0]      mem_pick;
    logic             mem_found;
    logic [IW-1:0]    mem_win;
    logic             sel_we;
    logic [15:0]      sel_adr;
    logic [15:0]      sel_wdat;

    always_comb begin
        // NOTE: every combinational output gets a default before any condition, so no latch is inferred.
        mem_req   = bus.core_read | bus.core_write;
        mem_pick  = rr_pick(mem_req, rr_ptr_q);
        mem_found = mem_pick[IW];
        mem_win   = mem_pick[IW-1:0];
        sel_we    = 1'b0;
        sel_adr   = '0;
        sel_wdat  = '0;
        for (int i = 0; i < NCORE; i++) begin
            if (IW'(i) == mem_win) begin
                sel_we   = bus.core_write[i];
                sel_adr  = bus.core_write[i] ? bus.core_write_adr[16*i +: 16]
                                             : bus.core_read_adr[16*i +: 16];
                sel_wdat = bus.core_write_dat[16*i +: 16];
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking '<=' so every register samples pre-edge values.
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            win_q      <= '0;
            op_we_q    <= 1'b0;
            cnt_q      <= '0;
            mem_adr_q  <= '0;
            mem_wdat_q <= '0;
            mem_we_q   <= 1'b0;
            mem_re_q   <= 1'b0;
            core_ac_q  <= '0;
            core_dat_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_found) begin
                        win_q      <= mem_win;
                        rr_ptr_q   <= next_ptr(mem_win);
                        op_we_q    <= sel_we;
                        mem_adr_q  <= sel_adr;
                        mem_wdat_q <= sel_wdat;
                        mem_we_q   <= sel_we;
                        mem_re_q   <= ~sel_we;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_we_q <= 1'b0;
                    mem_re_q <= 1'b0;
                    if (op_we_q) begin
                        core_ac_q[win_q] <= 1'b1;
                        state_q          <= RESP;
                    end else begin
                        cnt_q   <= CW'(LAT - 1);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        for (int i = 0; i < NCORE; i++) begin
                            if (IW'(i) == win_q) core_dat_q[16*i +: 16] <= bus.mem_rdat;
                        end
                        core_ac_q[win_q] <= 1'b1;
                        state_q          <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    core_ac_q <= '0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.core_ac  = core_ac_q;
    assign bus.core_dat = core_dat_q;
    assign bus.mem_adr  = mem_adr_q;
    assign bus.mem_wdat = mem_wdat_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_re   = mem_re_q;

    // Lock manager
    logic [NCORE-1:0] held_v_q;
    logic [9:0]       held_adr_q [NCORE];
    logic [IW-1:0]    lk_ptr_q;
    logic [NCORE-1:0] lock_ac_q;

    logic [NCORE-1:0] lk_blocked;
    logic [NCORE-1:0] lk_elig;
    logic [IW:0]      lk_pick;
    logic             lk_found;
    logic [IW-1:0]    lk_win;
    logic [9:0]       lk_adr_sel;
    logic [NCORE-1:0] held_v_d;
    logic [NCORE-1:0] lock_ac_d;

    always_comb begin
        lk_blocked = '0;
        for (int i = 0; i < NCORE; i++) begin
            for (int j = 0; j < NCORE; j++) begin
                if (j != i && held_v_q[j] && held_adr_q[j] == bus.core_lock_adr[10*i +: 10])
                    lk_blocked[i] = 1'b1;
            end
        end
        // Unlock from a core suppresses its own lock request this cycle.
        lk_elig    = bus.core_lock_en & ~bus.core_unlock_en & ~lock_ac_q & ~lk_blocked;
        lk_pick    = rr_pick(lk_elig, lk_ptr_q);
        lk_found   = lk_pick[IW];
        lk_win     = lk_pick[IW-1:0];
        lk_adr_sel = '0;
        held_v_d   = held_v_q & ~bus.core_unlock_en;
        lock_ac_d  = bus.core_unlock_en;
        for (int i = 0; i < NCORE; i++) begin
            if (lk_found && IW'(i) == lk_win) begin
                held_v_d[i]  = 1'b1;
                lock_ac_d[i] = 1'b1;
                lk_adr_sel   = bus.core_lock_adr[10*i +: 10];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            held_v_q  <= '0;
            lk_ptr_q  <= '0;
            lock_ac_q <= '0;
        end else begin
            held_v_q  <= held_v_d;
            lock_ac_q <= lock_ac_d;
            if (lk_found) lk_ptr_q <= next_ptr(lk_win);
        end
    end

    // NOTE: held_adr_q is deliberately not reset; held_v_q qualifies every entry.
    always_ff @(posedge clk) begin
        if (!reset && lk_found) held_adr_q[lk_win] <= lk_adr_sel;
    end

    assign bus.core_lock_ac = lock_ac_q;

endmodule
